// File: rtl/nonsynth_ethernet_receiver.sv
// Simulation-side AXI-Stream frame sink. It captures one frame into a word
// buffer, reports its byte length, and holds it for random-access reads until
// the host acknowledges it. Errored, malformed and oversize frames are dropped
// and counted in a saturating counter.
module nonsynth_ethernet_receiver #(
  parameter int buf_size_p         = 2048,
  parameter int recv_width_p       = 8,
  parameter int drop_count_width_p = 16,
  localparam int words_lp  = buf_size_p / recv_width_p,
  localparam int addr_w_lp = $clog2(words_lp),
  localparam int size_w_lp = $clog2(buf_size_p) + 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [recv_width_p*8-1:0]     rx_axis_tdata_i,
  input  logic [recv_width_p-1:0]       rx_axis_tkeep_i,
  input  logic                          rx_axis_tvalid_i,
  input  logic                          rx_axis_tlast_i,
  input  logic                          rx_axis_tuser_i,
  output logic                          rx_axis_tready_o,
  output logic                          packet_avail_o,
  output logic [size_w_lp-1:0]          packet_size_o,
  input  logic [addr_w_lp-1:0]          buffer_read_addr_i,
  output logic [recv_width_p*8-1:0]     buffer_read_data_o,
  input  logic                          packet_ack_i,
  output logic [drop_count_width_p-1:0] drop_count_o
);

  typedef enum logic [1:0] {RECV, HOLD, DROP} state_e;

  state_e                          state_r;
  logic [addr_w_lp:0]              wcnt_r;
  logic [size_w_lp-1:0]            packet_size_r;
  logic                            tready_r;
  logic                            avail_r;
  logic [drop_count_width_p-1:0]   drop_r;
  logic [recv_width_p*8-1:0]       mem [words_lp];

  logic                            hs;
  logic                            full;
  logic [recv_width_p-1:0]         keep_inc;
  logic                            keep_ok;
  logic [size_w_lp-1:0]            keep_bytes;
  logic [size_w_lp-1:0]            frame_size;
  logic [drop_count_width_p-1:0]   drop_next;

  // Parameter sanity: the buffer must hold a whole number of beats.
  initial begin
    if (buf_size_p % recv_width_p != 0) begin
      $error("buf_size_p (%0d) is not a multiple of recv_width_p (%0d)", buf_size_p, recv_width_p);
      $finish;
    end
  end

  // Only 8-byte beats are supported; checked continuously like the sender.
  always @(posedge clk_i) begin
    assert (recv_width_p == 8) else $error("recv_width_p must be 8");
  end

  // Beat decode: handshake, buffer-full, last-beat keep validity and frame size.
  always_comb begin
    hs         = rx_axis_tvalid_i & tready_r;
    full       = (wcnt_r == (addr_w_lp+1)'(words_lp));
    // A contiguous-from-bit-0 mask plus one has no bits in common with itself.
    keep_inc   = rx_axis_tkeep_i + {{(recv_width_p-1){1'b0}}, 1'b1};
    keep_ok    = (rx_axis_tkeep_i != '0) && ((keep_inc & rx_axis_tkeep_i) == '0);
    keep_bytes = size_w_lp'($countones(rx_axis_tkeep_i));
    frame_size = size_w_lp'(wcnt_r) * size_w_lp'(recv_width_p) + keep_bytes;
    drop_next  = (&drop_r) ? drop_r : drop_r + 1'b1;
  end

  // Frame FSM: receive into the buffer, hold a good frame, or discard a bad one.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r       <= RECV;
      wcnt_r        <= '0;
      packet_size_r <= '0;
      tready_r      <= 1'b1;
      avail_r       <= 1'b0;
      drop_r        <= '0;
    end else begin
      case (state_r)
        RECV: begin
          if (hs) begin
            if (full) begin
              if (rx_axis_tlast_i) begin
                drop_r <= drop_next;
                wcnt_r <= '0;
              end else begin
                state_r <= DROP;
              end
            end else if (rx_axis_tlast_i) begin
              if (!rx_axis_tuser_i && keep_ok) begin
                packet_size_r <= frame_size;
                wcnt_r        <= wcnt_r + 1'b1;
                state_r       <= HOLD;
                tready_r      <= 1'b0;
                avail_r       <= 1'b1;
              end else begin
                drop_r <= drop_next;
                wcnt_r <= '0;
              end
            end else begin
              wcnt_r <= wcnt_r + 1'b1;
            end
          end
        end
        DROP: begin
          if (hs && rx_axis_tlast_i) begin
            drop_r  <= drop_next;
            wcnt_r  <= '0;
            state_r <= RECV;
          end
        end
        HOLD: begin
          if (packet_ack_i) begin
            state_r  <= RECV;
            wcnt_r   <= '0;
            tready_r <= 1'b1;
            avail_r  <= 1'b0;
          end
        end
        default: state_r <= RECV;
      endcase
    end
  end

  // Buffer write port: accepted beats land at the current word count.
  // NOTE: the frame buffer is deliberately left out of reset; valid contents
  // are qualified by packet_avail_o and packet_size_o instead.
  always_ff @(posedge clk_i) begin
    if (state_r == RECV && hs && !full) begin
      mem[wcnt_r[addr_w_lp-1:0]] <= rx_axis_tdata_i;
    end
  end

  assign buffer_read_data_o = mem[buffer_read_addr_i];
  assign rx_axis_tready_o   = tready_r;
  assign packet_avail_o     = avail_r;
  assign packet_size_o      = packet_size_r;
  assign drop_count_o       = drop_r;

endmodule

// File: tb/tb_nonsynth_ethernet_receiver.sv
// Self-checking bench for nonsynth_ethernet_receiver: expected frames are
// queued as they are driven and compared when the DUT presents them.
module tb_nonsynth_ethernet_receiver;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [63:0] rx_axis_tdata_i;
  logic [7:0]  rx_axis_tkeep_i;
  logic        rx_axis_tvalid_i;
  logic        rx_axis_tlast_i;
  logic        rx_axis_tuser_i;
  logic        rx_axis_tready_o;
  logic        packet_avail_o;
  logic [11:0] packet_size_o;
  logic [7:0]  buffer_read_addr_i;
  logic [63:0] buffer_read_data_o;
  logic        packet_ack_i;
  logic [15:0] drop_count_o;

  int n_cmp = 0;
  int n_err = 0;
  int exp_drop = 0;
  int          exp_size_q[$];
  logic [63:0] exp_word_q[$];

  always #5 clk_i = ~clk_i;

  nonsynth_ethernet_receiver dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .rx_axis_tdata_i    (rx_axis_tdata_i),
    .rx_axis_tkeep_i    (rx_axis_tkeep_i),
    .rx_axis_tvalid_i   (rx_axis_tvalid_i),
    .rx_axis_tlast_i    (rx_axis_tlast_i),
    .rx_axis_tuser_i    (rx_axis_tuser_i),
    .rx_axis_tready_o   (rx_axis_tready_o),
    .packet_avail_o     (packet_avail_o),
    .packet_size_o      (packet_size_o),
    .buffer_read_addr_i (buffer_read_addr_i),
    .buffer_read_data_o (buffer_read_data_o),
    .packet_ack_i       (packet_ack_i),
    .drop_count_o       (drop_count_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] beat_word(input logic [7:0] seed, input int b);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[k*8 +: 8] = seed + 8'(b*8 + k);
    return w;
  endfunction

  // Present one beat at a negedge and return at the negedge after its handshake.
  task automatic drive_beat(input logic [63:0] d, input logic [7:0] keep,
                            input logic last, input logic user);
    int guard = 0;
    rx_axis_tvalid_i = 1'b1;
    rx_axis_tdata_i  = d;
    rx_axis_tkeep_i  = keep;
    rx_axis_tlast_i  = last;
    rx_axis_tuser_i  = user;
    while (!rx_axis_tready_o && guard < 1000) begin
      @(negedge clk_i);
      guard++;
    end
    if (guard >= 1000) check("tready_timeout", 64'(rx_axis_tready_o), 64'd1);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic send_frame(input int nbytes, input logic [7:0] seed, input logic user,
                            input bit use_keep, input logic [7:0] keep, input bit good);
    int beats = (nbytes + 7) / 8;
    int rem   = nbytes % 8;
    logic [7:0] lk;
    if (beats == 0) beats = 1;
    lk = (rem == 0) ? 8'hFF : (8'hFF >> (8 - rem));
    if (use_keep) lk = keep;
    if (good) begin
      exp_size_q.push_back(nbytes);
      for (int b = 0; b < beats; b++) exp_word_q.push_back(beat_word(seed, b));
    end else begin
      exp_drop = (exp_drop == 16'hFFFF) ? exp_drop : exp_drop + 1;
    end
    for (int b = 0; b < beats; b++) begin
      if (b == beats - 1) drive_beat(beat_word(seed, b), lk, 1'b1, user);
      else                drive_beat(beat_word(seed, b), 8'hFF, 1'b0, 1'b0);
    end
    rx_axis_tvalid_i = 1'b0;
    rx_axis_tlast_i  = 1'b0;
  endtask

  // Pop the oldest expected frame and compare it against the held buffer.
  task automatic verify_frame(input string tag);
    int sz;
    check({tag, "_avail"}, 64'(packet_avail_o), 64'd1);
    if (exp_size_q.size() == 0) begin
      check({tag, "_sb_underflow"}, 64'd1, 64'd0);
      return;
    end
    sz = exp_size_q.pop_front();
    check({tag, "_size"}, 64'(packet_size_o), 64'(sz));
    for (int w = 0; w < (sz + 7) / 8; w++) begin
      buffer_read_addr_i = 8'(w);
      #1;
      check({tag, "_word"}, buffer_read_data_o, exp_word_q.pop_front());
    end
    @(negedge clk_i);
  endtask

  task automatic do_ack(input string tag);
    packet_ack_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    packet_ack_i = 1'b0;
    check({tag, "_avail_after_ack"}, 64'(packet_avail_o), 64'd0);
    check({tag, "_tready_after_ack"}, 64'(rx_axis_tready_o), 64'd1);
  endtask

  task automatic expect_drop(input string tag);
    check({tag, "_no_avail"}, 64'(packet_avail_o), 64'd0);
    check({tag, "_drop_count"}, 64'(drop_count_o), 64'(exp_drop));
  endtask

  initial begin
    reset_i            = 1'b1;
    rx_axis_tdata_i    = '0;
    rx_axis_tkeep_i    = '0;
    rx_axis_tvalid_i   = 1'b0;
    rx_axis_tlast_i    = 1'b0;
    rx_axis_tuser_i    = 1'b0;
    buffer_read_addr_i = '0;
    packet_ack_i       = 1'b0;
    #1;
    check("rst_tready", 64'(rx_axis_tready_o), 64'd1);
    check("rst_avail",  64'(packet_avail_o), 64'd0);
    check("rst_size",   64'(packet_size_o), 64'd0);
    check("rst_drop",   64'(drop_count_o), 64'd0);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);

    // 64-byte frame, full last beat
    send_frame(64, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    verify_frame("f64");
    do_ack("f64");

    // 61-byte frame then 1-byte frame
    send_frame(61, 8'h10, 1'b0, 1'b0, 8'h00, 1'b1);
    verify_frame("f61");
    do_ack("f61");
    send_frame(1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b1);
    verify_frame("f1");
    do_ack("f1");

    // Bad last beats: tuser, empty keep, non-contiguous keep
    send_frame(24, 8'h20, 1'b1, 1'b0, 8'h00, 1'b0);
    expect_drop("err_user");
    send_frame(24, 8'h30, 1'b0, 1'b1, 8'h00, 1'b0);
    expect_drop("err_keep0");
    send_frame(24, 8'h40, 1'b0, 1'b1, 8'h05, 1'b0);
    expect_drop("err_keep5");
    check("err_drop_total", 64'(drop_count_o), 64'd3);

    // Exactly full buffer is accepted
    send_frame(2048, 8'h50, 1'b0, 1'b0, 8'h00, 1'b1);
    verify_frame("f2048");
    do_ack("f2048");

    // One beat too many: tlast lands on the overflow beat
    send_frame(2056, 8'h60, 1'b0, 1'b0, 8'h00, 1'b0);
    expect_drop("over2056");
    send_frame(64, 8'h70, 1'b0, 1'b0, 8'h00, 1'b1);
    verify_frame("after_over");
    do_ack("after_over");

    // Several beats past the end: discarded through the drop state
    send_frame(2072, 8'h80, 1'b0, 1'b0, 8'h00, 1'b0);
    expect_drop("over2072");
    send_frame(40, 8'h90, 1'b0, 1'b0, 8'h00, 1'b1);
    verify_frame("after_drop");
    do_ack("after_drop");

    // Backpressure: tvalid held in HOLD must not disturb the held frame
    send_frame(64, 8'hA0, 1'b0, 1'b0, 8'h00, 1'b1);
    rx_axis_tvalid_i = 1'b1;
    rx_axis_tdata_i  = 64'hDEAD_BEEF_0BAD_F00D;
    rx_axis_tkeep_i  = 8'hFF;
    rx_axis_tlast_i  = 1'b1;
    rx_axis_tuser_i  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("hold_tready", 64'(rx_axis_tready_o), 64'd0);
    end
    verify_frame("hold_buf");
    exp_size_q.push_back(8);
    exp_word_q.push_back(64'hDEAD_BEEF_0BAD_F00D);
    packet_ack_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    packet_ack_i = 1'b0;
    check("ack_tready_rise", 64'(rx_axis_tready_o), 64'd1);
    check("ack_avail_fall", 64'(packet_avail_o), 64'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rx_axis_tvalid_i = 1'b0;
    rx_axis_tlast_i  = 1'b0;
    verify_frame("held_beat");
    do_ack("held_beat");

    // Ack while receiving does nothing
    packet_ack_i = 1'b1;
    @(negedge clk_i);
    packet_ack_i = 1'b0;
    @(negedge clk_i);
    check("ack_recv_avail", 64'(packet_avail_o), 64'd0);
    check("ack_recv_tready", 64'(rx_axis_tready_o), 64'd1);
    check("ack_recv_drop", 64'(drop_count_o), 64'(exp_drop));

    // Async reset in the middle of a frame
    for (int b = 0; b < 3; b++) drive_beat(beat_word(8'hC0, b), 8'hFF, 1'b0, 1'b0);
    rx_axis_tvalid_i = 1'b0;
    #2 reset_i = 1'b1;
    #1;
    exp_drop = 0;
    check("mid_rst_tready", 64'(rx_axis_tready_o), 64'd1);
    check("mid_rst_avail",  64'(packet_avail_o), 64'd0);
    check("mid_rst_drop",   64'(drop_count_o), 64'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    send_frame(16, 8'hE0, 1'b0, 1'b0, 8'h00, 1'b1);
    verify_frame("post_rst");
    do_ack("post_rst");

    check("sb_empty", 64'(exp_size_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
